// File: rtl/partition_engine_if.sv
// Bundles the partition engine's control handshake and word-memory port.
// slave: engine side. master: range-stack controller plus word memory side.
interface partition_engine_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 12
);
    logic                 start;
    logic [ADDR_W-1:0]    lo;
    logic [ADDR_W-1:0]    hi;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    pivot_idx;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  start, lo, hi, mem_rdata,
        output busy, done, pivot_idx, mem_addr, mem_wdata, mem_read_en, mem_write_en
    );

    modport master (
        output start, lo, hi, mem_rdata,
        input  busy, done, pivot_idx, mem_addr, mem_wdata, mem_read_en, mem_write_en
    );
endinterface

// File: rtl/partition_engine.sv
// Lomuto partition of A[lo..hi] in a negedge-acting word memory; returns the pivot index.
// SIGNED_CMP_EN selects a two's-complement element compare (unsigned when undefined).
module partition_engine #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    partition_engine_if.slave   bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_PIV = 4'd1;
    localparam logic [3:0] S_RD_J   = 4'd2;
    localparam logic [3:0] S_CMP    = 4'd3;
    localparam logic [3:0] S_RD_I   = 4'd4;
    localparam logic [3:0] S_WR_J   = 4'd5;
    localparam logic [3:0] S_WR_I   = 4'd6;
    localparam logic [3:0] S_FIN_RD = 4'd7;
    localparam logic [3:0] S_FIN_WH = 4'd8;
    localparam logic [3:0] S_FIN_WI = 4'd9;
    localparam logic [3:0] S_DONE   = 4'd10;

    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    logic [3:0]           state_reg, state_next;
    logic [ADDR_W-1:0]    hi_reg, hi_next;
    logic [ADDR_W-1:0]    i_reg, i_next;
    logic [ADDR_W-1:0]    j_reg, j_next;
    logic [ADDR_W-1:0]    pivot_idx_reg, pivot_idx_next;
    logic [WORD_SIZE-1:0] pivot_reg, pivot_next;
    logic [WORD_SIZE-1:0] aj_reg, aj_next;
    logic [WORD_SIZE-1:0] ai_reg, ai_next;

    logic [ADDR_W-1:0]    i_inc, j_inc;
    logic                 aj_lt_pivot;

    assign i_inc = i_reg + IDX_ONE;
    assign j_inc = j_reg + IDX_ONE;

`ifdef SIGNED_CMP_EN
    assign aj_lt_pivot = $signed(aj_reg) < $signed(pivot_reg);
`else
    assign aj_lt_pivot = aj_reg < pivot_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        hi_next        = hi_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        pivot_idx_next = pivot_idx_reg;
        pivot_next     = pivot_reg;
        aj_next        = aj_reg;
        ai_next        = ai_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    hi_next = bus.hi;
                    i_next  = bus.lo;
                    j_next  = bus.lo;
                    if (bus.lo < bus.hi) begin
                        state_next = S_RD_PIV;
                    end else begin
                        pivot_idx_next = bus.lo;
                        state_next     = S_DONE;
                    end
                end
            end
            S_RD_PIV: begin
                pivot_next = bus.mem_rdata;
                state_next = S_RD_J;
            end
            S_RD_J: begin
                aj_next    = bus.mem_rdata;
                state_next = S_CMP;
            end
            S_CMP: begin
                // A swap with itself is skipped: advance both pointers without touching memory.
                if (aj_lt_pivot && (i_reg != j_reg)) begin
                    state_next = S_RD_I;
                end else begin
                    if (aj_lt_pivot) begin
                        i_next = i_inc;
                    end
                    j_next     = j_inc;
                    state_next = (j_inc == hi_reg) ? S_FIN_RD : S_RD_J;
                end
            end
            S_RD_I: begin
                ai_next    = bus.mem_rdata;
                state_next = S_WR_J;
            end
            S_WR_J: begin
                state_next = S_WR_I;
            end
            S_WR_I: begin
                i_next     = i_inc;
                j_next     = j_inc;
                state_next = (j_inc == hi_reg) ? S_FIN_RD : S_RD_J;
            end
            S_FIN_RD: begin
                if (i_reg == hi_reg) begin
                    pivot_idx_next = i_reg;
                    state_next     = S_DONE;
                end else begin
                    ai_next    = bus.mem_rdata;
                    state_next = S_FIN_WH;
                end
            end
            S_FIN_WH: begin
                state_next = S_FIN_WI;
            end
            S_FIN_WI: begin
                pivot_idx_next = i_reg;
                state_next     = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Memory port is a pure decode of the current state so it drops to zero at once on reset.
    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        case (state_reg)
            S_RD_PIV: begin
                bus.mem_addr    = hi_reg;
                bus.mem_read_en = 1'b1;
            end
            S_RD_J: begin
                bus.mem_addr    = j_reg;
                bus.mem_read_en = 1'b1;
            end
            S_RD_I: begin
                bus.mem_addr    = i_reg;
                bus.mem_read_en = 1'b1;
            end
            S_WR_J: begin
                bus.mem_addr     = j_reg;
                bus.mem_wdata    = ai_reg;
                bus.mem_write_en = 1'b1;
            end
            S_WR_I: begin
                bus.mem_addr     = i_reg;
                bus.mem_wdata    = aj_reg;
                bus.mem_write_en = 1'b1;
            end
            S_FIN_RD: begin
                if (i_reg != hi_reg) begin
                    bus.mem_addr    = i_reg;
                    bus.mem_read_en = 1'b1;
                end
            end
            S_FIN_WH: begin
                bus.mem_addr     = hi_reg;
                bus.mem_wdata    = ai_reg;
                bus.mem_write_en = 1'b1;
            end
            S_FIN_WI: begin
                bus.mem_addr     = i_reg;
                bus.mem_wdata    = pivot_reg;
                bus.mem_write_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.pivot_idx = pivot_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            hi_reg        <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            pivot_idx_reg <= '0;
            pivot_reg     <= '0;
            aj_reg        <= '0;
            ai_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            hi_reg        <= hi_next;
            i_reg         <= i_next;
            j_reg         <= j_next;
            pivot_idx_reg <= pivot_idx_next;
            pivot_reg     <= pivot_next;
            aj_reg        <= aj_next;
            ai_reg        <= ai_next;
        end
    end
endmodule

// File: tb/tb_partition_engine.sv
// Self-checking bench for partition_engine: vector table, pivot scoreboard, negedge word memory.
module tb_partition_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    partition_engine_if #(.WORD_SIZE(16), .ADDR_W(12)) bus();
    partition_engine #(.WORD_SIZE(16), .ADDR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0]      lo;
        logic [11:0]      hi;
        logic [4:0][15:0] init;
        logic [4:0][15:0] expv;
        logic [11:0]      piv;
        int               writes;
        int               reads;
    } vec_t;

    vec_t vecs[7];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int overlap_cnt = 0;
    int range_cnt = 0;
    logic [15:0]      mem [0:15];
    logic             ld_req = 1'b0;
    logic [3:0]       ld_base = 4'd0;
    logic [4:0][15:0] ld_img = '0;
    logic [11:0]      sb[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [4:0][15:0] pk(logic [15:0] a0, logic [15:0] a1, logic [15:0] a2,
                                            logic [15:0] a3, logic [15:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t mkv(logic [11:0] lo, logic [11:0] hi, logic [4:0][15:0] init,
                                 logic [4:0][15:0] expv, logic [11:0] piv, int wr, int rd);
        vec_t v;
        v.lo = lo; v.hi = hi; v.init = init; v.expv = expv;
        v.piv = piv; v.writes = wr; v.reads = rd;
        return v;
    endfunction

    // Word memory: acts on negedge, also takes bench image loads while the engine is idle.
    always @(negedge clk) begin
        if (ld_req) begin
            for (int k = 0; k < 5; k++) mem[ld_base + 4'(k)] <= ld_img[k];
        end
        if (bus.mem_read_en && bus.mem_write_en) overlap_cnt <= overlap_cnt + 1;
        if ((bus.mem_read_en || bus.mem_write_en) && bus.mem_addr > 12'd15) range_cnt <= range_cnt + 1;
        if (bus.mem_read_en) begin
            bus.mem_rdata <= mem[bus.mem_addr[3:0]];
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.mem_write_en) begin
            mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Done monitor pops the scoreboard.
    always begin
        logic [11:0] exp_piv;
        @(posedge clk);
        #1;
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: pivot_idx=%0d with no request outstanding", bus.pivot_idx);
            end else begin
                exp_piv = sb.pop_front();
                chk("pivot_idx_at_done", 32'(bus.pivot_idx), 32'(exp_piv));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic load(input logic [11:0] base, input logic [4:0][15:0] img);
        @(posedge clk);
        ld_base = base[3:0];
        ld_img  = img;
        ld_req  = 1'b1;
        @(posedge clk);
        ld_req  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int d0, rd0, wr0;
        load(v.lo, v.init);
        d0 = done_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.lo = v.lo; bus.hi = v.hi;
        sb.push_back(v.piv);
        @(negedge clk);
        bus.start = 1'b0; bus.lo = 12'($urandom); bus.hi = 12'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'(v.lo < v.hi));
        chk("done_after_start", 32'(bus.done), 32'(v.lo >= v.hi));
        if (v.lo < v.hi) begin
            bus.start = 1'b1; bus.lo = 12'd0; bus.hi = 12'd3;
            @(negedge clk);
            bus.start = 1'b0;
        end
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(negedge clk);
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("pivot_idx_hold", 32'(bus.pivot_idx), 32'(v.piv));
        chk("write_cycles", 32'(wr_cnt - wr0), 32'(v.writes));
        chk("read_cycles", 32'(rd_cnt - rd0), 32'(v.reads));
        for (int k = 0; k < 5; k++)
            chk($sformatf("mem[%0d]", v.lo + 12'(k)), 32'(mem[v.lo[3:0] + 4'(k)]), 32'(v.expv[k]));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        $display("txn lo=%0d hi=%0d pivot_idx=%0d reads=%0d writes=%0d",
                 v.lo, v.hi, bus.pivot_idx, rd_cnt - rd0, wr_cnt - wr0);
    endtask

    initial begin
        int d0;
        int found;
        logic [31:0] sum;
        bus.start = 1'b0; bus.lo = '0; bus.hi = '0;

        vecs[0] = mkv(12'd0, 12'd4, pk(5, 3, 8, 1, 4), pk(3, 1, 4, 5, 8), 12'd2, 6, 8);
        vecs[1] = mkv(12'd7, 12'd7, pk(11, 22, 33, 44, 55), pk(11, 22, 33, 44, 55), 12'd7, 0, 0);
        vecs[2] = mkv(12'd0, 12'd2, pk(1, 2, 3, 9, 9), pk(1, 2, 3, 9, 9), 12'd2, 0, 3);
        vecs[3] = mkv(12'd0, 12'd2, pk(4, 4, 4, 9, 9), pk(4, 4, 4, 9, 9), 12'd0, 2, 4);
        vecs[4] = mkv(12'd5, 12'd3, pk(6, 6, 6, 6, 6), pk(6, 6, 6, 6, 6), 12'd5, 0, 0);
`ifdef SIGNED_CMP_EN
        vecs[5] = mkv(12'd0, 12'd1, pk(16'hFFFF, 1, 9, 9, 9), pk(16'hFFFF, 1, 9, 9, 9), 12'd1, 0, 2);
`else
        vecs[5] = mkv(12'd0, 12'd1, pk(16'hFFFF, 1, 9, 9, 9), pk(1, 16'hFFFF, 9, 9, 9), 12'd0, 2, 3);
`endif
        vecs[6] = mkv(12'd2, 12'd6, pk(2, 9, 1, 7, 5), pk(2, 1, 5, 7, 9), 12'd4, 4, 7);

        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pivot_idx", 32'(bus.pivot_idx), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_read_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_write_en), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 7; n++) run_vec(vecs[n]);

        // Reset asserted during the first WR_J of the {5,3,8,1,4} partition.
        load(12'd0, pk(5, 3, 8, 1, 4));
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.lo = 12'd0; bus.hi = 12'd4;
        sb.push_back(12'd2);
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(posedge clk);
            #2;
            if (bus.mem_write_en) found = 1;
        end
        chk("reached_wr_j", 32'(found), 32'd1);
        chk("wr_j_addr", 32'(bus.mem_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_pivot_idx", 32'(bus.pivot_idx), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("midrst_mem_re", 32'(bus.mem_read_en), 32'd0);
        chk("midrst_mem_we", 32'(bus.mem_write_en), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        sum = 0;
        for (int k = 0; k < 5; k++) sum = sum + 32'(mem[k]);
        chk("midrst_permutation_sum", sum, 32'd21);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        chk("rd_wr_overlap", 32'(overlap_cnt), 32'd0);
        chk("addr_range", 32'(range_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
